// File: rtl/mmio_uart_bridge.sv
// mmio_uart_bridge: memory-mapped UART bridge with TX/RX FIFOs, a LED
// register and an interrupt line, sitting on the EX/MEM load/store port.
module mmio_uart_bridge #(
    parameter int unsigned TX_DEPTH  = 8,
    parameter int unsigned RX_DEPTH  = 8,
    parameter int unsigned LED_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [31:0]          addr,
    input  logic [31:0]          wdata,
    input  logic                 we,
    input  logic                 re,
    output logic [31:0]          rdata,
    output logic                 hit,
    output logic [7:0]           uart_tx_data,
    output logic                 uart_tx_we,
    input  logic                 uart_tx_busy,
    input  logic [7:0]           uart_rx_data,
    input  logic                 uart_rx_valid,
    output logic                 uart_rx_re,
    output logic [LED_WIDTH-1:0] led_out,
    output logic                 irq
);

    localparam int unsigned TX_AW = $clog2(TX_DEPTH);
    localparam int unsigned TX_CW = TX_AW + 1;
    localparam int unsigned RX_AW = $clog2(RX_DEPTH);
    localparam int unsigned RX_CW = RX_AW + 1;

    localparam logic [31:0] ADDR_DATA   = 32'h1000_0000;
    localparam logic [31:0] ADDR_STATUS = 32'h1000_0004;
    localparam logic [31:0] ADDR_CTRL   = 32'h1000_0008;
    localparam logic [31:0] ADDR_LED    = 32'h2000_0000;

    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_PULSE = 2'd1,
        TX_WAIT  = 2'd2
    } tx_state_t;

    typedef enum logic {
        RX_IDLE = 1'b0,
        RX_ACK  = 1'b1
    } rx_state_t;

    tx_state_t tx_state;
    rx_state_t rx_state;

    logic [7:0]       tx_mem [TX_DEPTH];
    logic [TX_AW-1:0] tx_wr_ptr;
    logic [TX_AW-1:0] tx_rd_ptr;
    logic [TX_CW-1:0] tx_count;

    logic [7:0]       rx_mem [RX_DEPTH];
    logic [RX_AW-1:0] rx_wr_ptr;
    logic [RX_AW-1:0] rx_rd_ptr;
    logic [RX_CW-1:0] rx_count;

    logic                 tx_ovf;
    logic                 rx_irq_en;
    logic                 tx_irq_en;
    logic [LED_WIDTH-1:0] led_q;

    logic sel_data, sel_status, sel_ctrl, sel_led;
    logic tx_full, tx_empty, rx_full, rx_nonempty;
    logic tx_push, tx_pop, rx_push, rx_pop;
    logic ovf_set, ovf_clr;

    // Only the low store byte and the LED field are architecturally used.
    logic unused_wdata_bits;
    assign unused_wdata_bits = ^wdata;

    // Exact-word address decode.
    assign sel_data   = (addr == ADDR_DATA);
    assign sel_status = (addr == ADDR_STATUS);
    assign sel_ctrl   = (addr == ADDR_CTRL);
    assign sel_led    = (addr == ADDR_LED);
    assign hit        = sel_data | sel_status | sel_ctrl | sel_led;

    assign tx_full     = (tx_count == TX_CW'(TX_DEPTH));
    assign tx_empty    = (tx_count == '0);
    assign rx_full     = (rx_count == RX_CW'(RX_DEPTH));
    assign rx_nonempty = (rx_count != '0);

    // Fullness is judged on the pre-edge count, so a same-cycle drain does not rescue a write.
    assign tx_push = we & sel_data & ~tx_full;
    assign ovf_set = we & sel_data & tx_full;
    assign ovf_clr = we & sel_status & wdata[3];
    assign tx_pop  = (tx_state == TX_IDLE) & ~tx_empty & ~uart_tx_busy;

    assign rx_pop  = re & sel_data & rx_nonempty;
    assign rx_push = (rx_state == RX_IDLE) & uart_rx_valid & ~rx_full;

    assign led_out = led_q;
    assign irq     = (rx_irq_en & rx_nonempty) | (tx_irq_en & tx_empty);

    // Load data mux; unmapped addresses read zero.
    always_comb begin
        rdata = 32'h0;
        if (sel_data) begin
            rdata = rx_nonempty ? {24'h0, rx_mem[rx_rd_ptr]} : 32'h0;
        end else if (sel_status) begin
            rdata = {8'h0, 8'(tx_count), 8'(rx_count),
                     4'h0, tx_ovf, tx_empty, tx_full, rx_nonempty};
        end else if (sel_ctrl) begin
            rdata = {30'h0, tx_irq_en, rx_irq_en};
        end else if (sel_led) begin
            rdata = 32'(led_q);
        end
    end

    // FIFO storage arrays; contents need no reset since pointers and counts gate them.
    always_ff @(posedge clk) begin
        if (tx_push) begin
            tx_mem[tx_wr_ptr] <= wdata[7:0];
        end
        if (rx_push) begin
            rx_mem[rx_wr_ptr] <= uart_rx_data;
        end
    end

    // TX FIFO pointers and occupancy.
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_wr_ptr <= '0;
            tx_rd_ptr <= '0;
            tx_count  <= '0;
        end else begin
            if (tx_push) tx_wr_ptr <= tx_wr_ptr + TX_AW'(1);
            if (tx_pop)  tx_rd_ptr <= tx_rd_ptr + TX_AW'(1);
            case ({tx_push, tx_pop})
                2'b10:   tx_count <= tx_count + TX_CW'(1);
                2'b01:   tx_count <= tx_count - TX_CW'(1);
                default: tx_count <= tx_count;
            endcase
        end
    end

    // RX FIFO pointers and occupancy.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_wr_ptr <= '0;
            rx_rd_ptr <= '0;
            rx_count  <= '0;
        end else begin
            if (rx_push) rx_wr_ptr <= rx_wr_ptr + RX_AW'(1);
            if (rx_pop)  rx_rd_ptr <= rx_rd_ptr + RX_AW'(1);
            case ({rx_push, rx_pop})
                2'b10:   rx_count <= rx_count + RX_CW'(1);
                2'b01:   rx_count <= rx_count - RX_CW'(1);
                default: rx_count <= rx_count;
            endcase
        end
    end

    // Control registers: sticky overflow (set beats clear), interrupt enables, LEDs.
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_ovf    <= 1'b0;
            rx_irq_en <= 1'b0;
            tx_irq_en <= 1'b0;
            led_q     <= '0;
        end else begin
            if (ovf_set) begin
                tx_ovf <= 1'b1;
            end else if (ovf_clr) begin
                tx_ovf <= 1'b0;
            end
            if (we && sel_ctrl) begin
                rx_irq_en <= wdata[0];
                tx_irq_en <= wdata[1];
            end
            if (we && sel_led) begin
                led_q <= wdata[LED_WIDTH-1:0];
            end
        end
    end

    // TX drain FSM: pop the head byte into the output register and strobe it for one cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_state     <= TX_IDLE;
            uart_tx_we   <= 1'b0;
            uart_tx_data <= 8'h0;
        end else begin
            uart_tx_we <= 1'b0;
            case (tx_state)
                TX_IDLE: begin
                    if (tx_pop) begin
                        tx_state     <= TX_PULSE;
                        uart_tx_we   <= 1'b1;
                        uart_tx_data <= tx_mem[tx_rd_ptr];
                    end
                end
                TX_PULSE: tx_state <= TX_WAIT;
                TX_WAIT: begin
                    if (!uart_tx_busy) tx_state <= TX_IDLE;
                end
                default: tx_state <= TX_IDLE;
            endcase
        end
    end

    // RX capture FSM: take a byte only when there is room, then acknowledge it for one cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_state   <= RX_IDLE;
            uart_rx_re <= 1'b0;
        end else begin
            uart_rx_re <= 1'b0;
            case (rx_state)
                RX_IDLE: begin
                    if (rx_push) begin
                        rx_state   <= RX_ACK;
                        uart_rx_re <= 1'b1;
                    end
                end
                RX_ACK:  rx_state <= RX_IDLE;
                default: rx_state <= RX_IDLE;
            endcase
        end
    end

endmodule

// File: doc/mmio_uart_bridge.md
MMIO_UART_BRIDGE -- requirements
Module: mmio_uart_bridge

Interface
REQ-001 SHALL have parameter TX_DEPTH, default 8: TX FIFO entries, power of 2, 2..128.
REQ-002 SHALL have parameter RX_DEPTH, default 8: RX FIFO entries, power of 2, 2..128.
REQ-003 SHALL have parameter LED_WIDTH, default 16: LED register width, 1..32.
REQ-004 SHALL have ports, clock and reset first:
- clk  in  1  sole clock; all state updates on posedge.
- rst  in  1  reset, synchronous, active-high.
- addr  in  32  byte address from the EX/MEM ALU result.
- wdata  in  32  store data.
- we  in  1  store strobe.
- re  in  1  load strobe.
- rdata  out  32  load data, combinational.
- hit  out  1  addr matches a mapped register.
- uart_tx_data  out  8  byte to the UART transmitter.
- uart_tx_we  out  1  one-cycle transmit strobe.
- uart_tx_busy  in  1  transmitter busy.
- uart_rx_data  in  8  received byte.
- uart_rx_valid  in  1  level: received byte available.
- uart_rx_re  out  1  one-cycle receive acknowledge.
- led_out  out  LED_WIDTH  LED register.
- irq  out  1  interrupt request.

Function
REQ-005 Address map, exact word match: 0x1000_0000 DATA; 0x1000_0004 STATUS; 0x1000_0008 CTRL; 0x2000_0000 LED. hit SHALL be 1 only for these four addresses.
REQ-006 Unmapped addresses: rdata SHALL be 0, writes ignored, no side effects.
REQ-007 DATA read: rdata = {24'b0, RX head}, or 0 if RX is empty. If re=1 and RX is non-empty, pop at that posedge; re on an empty RX has no effect.
REQ-008 DATA write: push wdata[7:0] to TX. If TX is full, the byte is dropped and tx_ovf (sticky) is set. Fullness uses the count registered before the edge, even if a drain pop occurs in the same cycle.
REQ-009 STATUS read bits:
- [0] rx_nonempty
- [1] tx_full
- [2] tx_empty
- [3] tx_ovf
- [15:8] rx_count
- [23:16] tx_count
- all other bits 0.
REQ-010 STATUS write: a 1 in wdata[3] clears tx_ovf; all other bits are ignored. If an overflow occurs in the same cycle as the clear, the set wins.
REQ-011 CTRL read/write bits: [0] rx_irq_en, [1] tx_irq_en; other bits read 0.
REQ-012 LED read/write: led_out = wdata[LED_WIDTH-1:0]; rdata zero-extended.
REQ-013 irq = (rx_irq_en & rx_nonempty) | (tx_irq_en & tx_empty), combinational from registered state.
REQ-014 FIFOs are circular. Pointers wrap modulo depth. Count width is log2(DEPTH)+1. A simultaneous push and pop leaves the count unchanged.
REQ-015 TX drain FSM, states TX_IDLE, TX_PULSE, TX_WAIT:
- TX_IDLE -> TX_PULSE when TX is non-empty and uart_tx_busy=0. On that edge, uart_tx_data loads the head byte and the FIFO pops.
- TX_PULSE: uart_tx_we=1 for exactly this cycle; -> TX_WAIT unconditionally.
- TX_WAIT -> TX_IDLE when uart_tx_busy=0.
REQ-016 TX latency: a DATA write at edge N gives uart_tx_we=1 in the cycle after edge N+1, when the FSM is idle and the UART is not busy.
REQ-017 RX capture FSM, states RX_IDLE, RX_ACK:
- RX_IDLE -> RX_ACK when uart_rx_valid=1 and RX is not full; uart_rx_data is pushed on that edge.
- RX_ACK: uart_rx_re=1 for exactly this cycle; -> RX_IDLE.
- When RX is full, the byte is not acknowledged and stays in the UART. No data is lost.
REQ-018 we and re may both be high in one cycle; each takes effect independently. A DATA write and a DATA read in the same cycle push TX and pop RX.
REQ-019 uart_tx_we, uart_rx_re and uart_tx_data SHALL be registered outputs.

Reset
REQ-020 While rst=1 at a posedge, the block SHALL reset to:
- both FIFOs empty, pointers 0;
- both FSMs in idle (TX_IDLE, RX_IDLE);
- tx_ovf=0, CTRL=0, led_out=0;
- uart_tx_we=0, uart_rx_re=0, uart_tx_data=0.
Consequently irq=0.
REQ-021 Reset mid-transfer SHALL abort the transfer: a pending uart_tx_we is cancelled, queued bytes are discarded, and no acknowledge is issued for a byte presented during reset.

Verification
REQ-022 Reset, then read STATUS -> rdata=0x0000_0004; led_out=0; irq=0.
REQ-023 With busy=0, write 0x41 then 0x42 to DATA -> two uart_tx_we pulses carrying 0x41 then 0x42, in order, each one cycle wide.
REQ-024 Hold busy=1 and write 9 bytes (TX_DEPTH=8) -> STATUS=0x0008_000A (tx_full, tx_ovf, tx_count 8); the 9th byte is never sent. Write 0x8 to STATUS -> tx_ovf=0.
REQ-025 Present uart_rx_valid=1 with data 0x5A for 9 bytes while the CPU does not read (RX_DEPTH=8) -> exactly 8 uart_rx_re pulses; rx_count=8; the 9th byte is held. Read DATA -> rdata=0x5A; on the next cycle the 9th byte is acknowledged.
REQ-026 Write CTRL=0x1, then receive one byte -> irq=1. Read DATA -> irq=0 and STATUS[0]=0. Read DATA again -> rdata=0.
REQ-027 Write 0xFFFF_A5A5 to LED -> led_out=0xA5A5. Write 0x1234 to 0x3000_0000 -> hit=0, no state change, and a read of that address returns 0.
